municao_pool: RTL

- Enemy ammunition pool: holds up to N_SLOTS independent enemy shots, fires periodically from the current enemy position, moves all live shots downward on a shared movement tick, and retires them at the screen limit or on external kill.
- Generates one registered RGB layer for the VGA mixer. It sits beside the enemy ship block and the collision logic.
- Successor to the single-shot enemy ammo block. Adds multi-slot allocation, kill input, fire enable and a drop indication.

---
 rtl/municao_pkg.sv | 35 +++
 rtl/municao_slot.sv | 88 ++++++++
 rtl/municao_pool.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/municao_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : municao_pkg
//  Description : Shared definitions for the enemy ammunition pool: screen
//                limits, blanking thresholds, colours, delay defaults and a
//                counter-width helper.
//  Revision    : 1.0 - initial multi-slot release
// ============================================================================
package municao_pkg;

    // Screen constants
    localparam int Y_LIMIT_DEFAULT    = 540;
    localparam int H_BLANK_DEFAULT    = 96;
    localparam int V_BLANK_DEFAULT    = 2;

    // Timer defaults (terminal count, i.e. period minus one)
    localparam int DELAY_MOVE_DEFAULT = 200000;
    localparam int DELAY_FIRE_DEFAULT = 50000000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t SHOT_RGB  = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t BLACK_RGB = '{r: 8'h00, g: 8'h00, b: 8'h00};

    // Bits needed for a counter running 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : municao_pkg
`default_nettype wire

// File: rtl/municao_slot.sv
`default_nettype none
// ============================================================================
//  Module      : municao_slot
//  Description : One enemy shot slot. Holds x/y/active, applies the
//                kill > spawn > move priority and produces a pixel hit bit.
//  Ports       : clk, reset (async, active low), i_kill, i_spawn,
//                i_move_tick, i_spawn_x/y, i_pix_h/v -> o_x, o_y, o_active,
//                o_hit
//  Revision    : 1.0 - initial release
// ============================================================================
module municao_slot
    import municao_pkg::*;
#(
    parameter int CW      = 11,
    parameter int STEP    = 1,
    parameter int Y_LIMIT = Y_LIMIT_DEFAULT,
    parameter int SHOT_W  = 2,
    parameter int SHOT_H  = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_kill,
    input  logic          i_spawn,
    input  logic          i_move_tick,
    input  logic [CW-1:0] i_spawn_x,
    input  logic [CW-1:0] i_spawn_y,
    input  logic [CW-1:0] i_pix_h,
    input  logic [CW-1:0] i_pix_v,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_active,
    output logic          o_hit
);

    localparam logic [CW:0] c_step    = (CW+1)'(STEP);
    localparam logic [CW:0] c_y_limit = (CW+1)'(Y_LIMIT);
    localparam logic [CW:0] c_shot_w  = (CW+1)'(SHOT_W);
    localparam logic [CW:0] c_shot_h  = (CW+1)'(SHOT_H);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_active;

    // One extra bit so positions near the top of the range never wrap.
    logic [CW:0] w_y_next;
    logic [CW:0] w_x_end;
    logic [CW:0] w_y_end;

    assign w_y_next = {1'b0, r_y} + c_step;
    assign w_x_end  = {1'b0, r_x} + c_shot_w;
    assign w_y_end  = {1'b0, r_y} + c_shot_h;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_active <= 1'b0;
        end else if (i_kill) begin
            // x is kept on kill; inactive slots already sit at y=0.
            if (r_active) begin
                r_active <= 1'b0;
                r_y      <= '0;
            end
        end else if (i_spawn) begin
            // A fresh shot does not move in its spawn cycle.
            r_x      <= i_spawn_x;
            r_y      <= i_spawn_y;
            r_active <= 1'b1;
        end else if (i_move_tick && r_active) begin
            if (w_y_next < c_y_limit) begin
                r_y <= w_y_next[CW-1:0];
            end else begin
                r_active <= 1'b0;
                r_y      <= '0;
            end
        end
    end

    assign o_hit = r_active
                && (i_pix_h >= r_x) && ({1'b0, i_pix_h} < w_x_end)
                && (i_pix_v >= r_y) && ({1'b0, i_pix_v} < w_y_end);

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_active = r_active;

endmodule : municao_slot
`default_nettype wire

// File: rtl/municao_pool.sv
`default_nettype none
// ============================================================================
//  Module      : municao_pool
//  Description : Enemy ammunition pool. Periodically fires from the enemy
//                position into the lowest free slot, moves live shots down on
//                a shared tick, retires them at the limit or on kill, and
//                renders a registered RGB layer.
//  Ports       : clk, reset (async, active low), fire_en, posX/posY_inimigo,
//                kill[N_SLOTS], h_counter, v_counter -> shot_x, shot_y,
//                shot_active, fire_dropped, R, G, B
//  Revision    : 1.0 - multi-slot successor of the single-shot block
// ============================================================================
module municao_pool
    import municao_pkg::*;
#(
    parameter int N_SLOTS    = 4,
    parameter int CW         = 11,
    parameter int DELAY_MOVE = DELAY_MOVE_DEFAULT,
    parameter int DELAY_FIRE = DELAY_FIRE_DEFAULT,
    parameter int STEP       = 1,
    parameter int Y_LIMIT    = Y_LIMIT_DEFAULT,
    parameter int SHOT_W     = 2,
    parameter int SHOT_H     = 20,
    parameter int H_BLANK    = H_BLANK_DEFAULT,
    parameter int V_BLANK    = V_BLANK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fire_en,
    input  logic [CW-1:0]         posX_inimigo,
    input  logic [CW-1:0]         posY_inimigo,
    input  logic [N_SLOTS-1:0]    kill,
    input  logic [9:0]            h_counter,
    input  logic [9:0]            v_counter,
    output logic [N_SLOTS*CW-1:0] shot_x,
    output logic [N_SLOTS*CW-1:0] shot_y,
    output logic [N_SLOTS-1:0]    shot_active,
    output logic                  fire_dropped,
    output logic [7:0]            R,
    output logic [7:0]            G,
    output logic [7:0]            B
);

    localparam int MW = cnt_width(DELAY_MOVE);
    localparam int FW = cnt_width(DELAY_FIRE);
    localparam logic [MW-1:0] c_move_max = MW'(DELAY_MOVE);
    localparam logic [FW-1:0] c_fire_max = FW'(DELAY_FIRE);
    localparam logic [9:0]    c_h_blank  = 10'(H_BLANK);
    localparam logic [9:0]    c_v_blank  = 10'(V_BLANK);

    logic [MW-1:0]      r_move_cnt;
    logic [FW-1:0]      r_fire_cnt;
    logic               r_fire_dropped;
    rgb_t               r_rgb;

    logic               w_move_tick;
    logic               w_fire_tick;
    logic [N_SLOTS-1:0] w_spawn;
    logic               w_found;
    logic [N_SLOTS-1:0] w_hit;
    logic [CW-1:0]      w_pix_h;
    logic [CW-1:0]      w_pix_v;

    assign w_move_tick = (r_move_cnt == c_move_max);
    assign w_fire_tick = fire_en && (r_fire_cnt == c_fire_max);

    // Movement timer is free-running; fire timer holds while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_move_cnt <= '0;
            r_fire_cnt <= '0;
        end else begin
            r_move_cnt <= w_move_tick ? '0 : r_move_cnt + MW'(1);
            if (fire_en) begin
                r_fire_cnt <= w_fire_tick ? '0 : r_fire_cnt + FW'(1);
            end
        end
    end

    // Lowest-index free slot. A slot being killed this cycle is not free
    // yet; it becomes allocatable one cycle later.
    always_comb begin
        w_spawn = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!w_found && !shot_active[i] && !kill[i]) begin
                w_found    = 1'b1;
                w_spawn[i] = w_fire_tick;
            end
        end
    end

    assign w_pix_h = CW'(h_counter);
    assign w_pix_v = CW'(v_counter);

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        municao_slot #(
            .CW      (CW),
            .STEP    (STEP),
            .Y_LIMIT (Y_LIMIT),
            .SHOT_W  (SHOT_W),
            .SHOT_H  (SHOT_H)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_kill      (kill[i]),
            .i_spawn     (w_spawn[i]),
            .i_move_tick (w_move_tick),
            .i_spawn_x   (posX_inimigo),
            .i_spawn_y   (posY_inimigo),
            .i_pix_h     (w_pix_h),
            .i_pix_v     (w_pix_v),
            .o_x         (shot_x[i*CW +: CW]),
            .o_y         (shot_y[i*CW +: CW]),
            .o_active    (shot_active[i]),
            .o_hit       (w_hit[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fire_dropped <= 1'b0;
            r_rgb          <= BLACK_RGB;
        end else begin
            r_fire_dropped <= w_fire_tick && !w_found;
            if ((v_counter <= c_v_blank) || (h_counter <= c_h_blank)) begin
                r_rgb <= BLACK_RGB;
            end else if (|w_hit) begin
                r_rgb <= SHOT_RGB;
            end else begin
                r_rgb <= BLACK_RGB;
            end
        end
    end

    assign fire_dropped = r_fire_dropped;
    assign R            = r_rgb.r;
    assign G            = r_rgb.g;
    assign B            = r_rgb.b;

endmodule : municao_pool
`default_nettype wire
